// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: state/LED codes, display codes, key priority.
// Pure definitions; no latency, no backpressure.
package calc_pkg;

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_OP_A     = 3'd1,
        S_OP_A_NEG = 3'd2,
        S_OPRND    = 3'd3,
        S_OP_B     = 3'd4,
        S_OP_B_NEG = 3'd5,
        S_RESULT   = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    localparam logic [1:0] DISP_A   = 2'b00;
    localparam logic [1:0] DISP_B   = 2'b01;
    localparam logic [1:0] DISP_RES = 2'b10;
    localparam logic [1:0] DISP_ERR = 2'b11;

    typedef enum logic [3:0] {
        K_NONE, K_EX, K_OP, K_SUB, K_DIG, K_BKSP, K_MR, K_MS, K_MC
    } key_t;

    // Only the highest-priority key pressed in a cycle is acted upon.
    function automatic key_t pick_key(input logic ex, input logic op, input logic sub,
                                      input logic dig, input logic bksp, input logic mr,
                                      input logic ms, input logic mc);
        key_t k;
        if (ex)        k = K_EX;
        else if (op)   k = K_OP;
        else if (sub)  k = K_SUB;
        else if (dig)  k = K_DIG;
        else if (bksp) k = K_BKSP;
        else if (mr)   k = K_MR;
        else if (ms)   k = K_MS;
        else if (mc)   k = K_MC;
        else           k = K_NONE;
        return k;
    endfunction

    function automatic logic [1:0] disp_of(input state_t s);
        logic [1:0] d;
        case (s)
            S_START, S_OP_A, S_OP_A_NEG: d = DISP_A;
            S_OPRND, S_OP_B, S_OP_B_NEG: d = DISP_B;
            S_RESULT:                    d = DISP_RES;
            default:                     d = DISP_ERR;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// Saturating digit counter: clear (with optional load-one), load-max, inc, dec; updates next posedge.
// No backpressure: saturating requests are dropped silently.
module calc_digit_counter
    import calc_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = 3
)(
    input  logic         clock,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_ld_max,
    output logic [W-1:0] o_cnt,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_cnt;

    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == W'(MAX));
    assign o_empty = (r_cnt == '0);

    // clr together with inc restarts the count at one (first digit of a fresh operand).
    always_ff @(posedge clock) begin
        if (i_clr)
            r_cnt <= i_inc ? W'(1) : '0;
        else if (i_ld_max)
            r_cnt <= W'(MAX);
        else if (i_inc && !o_full)
            r_cnt <= r_cnt + 1'b1;
        else if (i_dec && !o_empty)
            r_cnt <= r_cnt - 1'b1;
    end

endmodule

// File: rtl/calc_control_seq.sv
// Calculator keypad sequencer: Mealy strobes in the key-pulse cycle; state, counters, mem_valid next posedge.
// No backpressure: each key pulse is consumed or ignored in its own cycle.
module calc_control_seq
    import calc_pkg::*;
#(
    parameter  int MAX_DIGITS = 4,
    parameter  int CHAIN_EN   = 1,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
)(
    input  logic             clock,
    input  logic             reset_in,
    input  logic             clr_in,
    input  logic             dig_in,
    input  logic             op_in,
    input  logic             sub_in,
    input  logic             ex_in,
    input  logic             bksp_in,
    input  logic             ms_in,
    input  logic             mr_in,
    input  logic             mc_in,
    input  logic             err_in,
    output logic             load_A,
    output logic             load_B,
    output logic             bksp_A,
    output logic             bksp_B,
    output logic             load_op,
    output logic             execute,
    output logic             reset_out,
    output logic             chain,
    output logic             mem_store,
    output logic             mem_recall_A,
    output logic             mem_recall_B,
    output logic             mem_clear,
    output logic             mem_valid,
    output logic [CNT_W-1:0] cnt_A,
    output logic [CNT_W-1:0] cnt_B,
    output logic [1:0]       display_select,
    output logic [2:0]       LED
);

    state_t r_state;
    logic   r_mem_valid;
    logic   r_neg_a;
    logic   r_neg_b;

    key_t   w_key;
    state_t w_nxt;
    logic   w_mem_nxt, w_neg_a_nxt, w_neg_b_nxt;
    logic   w_a_clr, w_a_inc, w_a_dec, w_a_ldmax, w_a_full, w_a_empty;
    logic   w_b_clr, w_b_inc, w_b_dec, w_b_ldmax, w_b_full, w_b_empty;

    calc_digit_counter #(.MAX(MAX_DIGITS), .W(CNT_W)) u_cnt_a (
        .clock(clock), .i_clr(w_a_clr), .i_inc(w_a_inc), .i_dec(w_a_dec),
        .i_ld_max(w_a_ldmax), .o_cnt(cnt_A), .o_full(w_a_full), .o_empty(w_a_empty)
    );

    calc_digit_counter #(.MAX(MAX_DIGITS), .W(CNT_W)) u_cnt_b (
        .clock(clock), .i_clr(w_b_clr), .i_inc(w_b_inc), .i_dec(w_b_dec),
        .i_ld_max(w_b_ldmax), .o_cnt(cnt_B), .o_full(w_b_full), .o_empty(w_b_empty)
    );

    assign mem_valid      = r_mem_valid;
    assign LED            = r_state;
    assign display_select = disp_of(r_state);

    always_comb begin
        w_key        = pick_key(ex_in, op_in, sub_in, dig_in, bksp_in, mr_in, ms_in, mc_in);
        load_A       = 1'b0;
        load_B       = 1'b0;
        bksp_A       = 1'b0;
        bksp_B       = 1'b0;
        load_op      = 1'b0;
        execute      = 1'b0;
        reset_out    = 1'b0;
        chain        = 1'b0;
        mem_store    = 1'b0;
        mem_recall_A = 1'b0;
        mem_recall_B = 1'b0;
        mem_clear    = 1'b0;
        w_nxt        = r_state;
        w_mem_nxt    = r_mem_valid;
        w_neg_a_nxt  = r_neg_a;
        w_neg_b_nxt  = r_neg_b;
        w_a_clr      = 1'b0;
        w_a_inc      = 1'b0;
        w_a_dec      = 1'b0;
        w_a_ldmax    = 1'b0;
        w_b_clr      = 1'b0;
        w_b_inc      = 1'b0;
        w_b_dec      = 1'b0;
        w_b_ldmax    = 1'b0;

        if (reset_in || clr_in) begin
            reset_out   = 1'b1;
            w_nxt       = S_START;
            w_a_clr     = 1'b1;
            w_b_clr     = 1'b1;
            w_neg_a_nxt = 1'b0;
            w_neg_b_nxt = 1'b0;
            if (reset_in)
                w_mem_nxt = 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    reset_out = 1'b1;
                    if (w_key == K_DIG) begin
                        reset_out = 1'b0; load_A = 1'b1; w_a_clr = 1'b1; w_a_inc = 1'b1;
                        w_neg_a_nxt = 1'b0; w_nxt = S_OP_A;
                    end else if (w_key == K_SUB) begin
                        reset_out = 1'b0; load_A = 1'b1; w_nxt = S_OP_A_NEG;
                    end else if (w_key == K_MR && r_mem_valid) begin
                        reset_out = 1'b0; mem_recall_A = 1'b1; w_a_ldmax = 1'b1;
                        w_neg_a_nxt = 1'b0; w_nxt = S_OP_A;
                    end
                end
                S_OP_A: begin
                    if (w_key == K_DIG && !w_a_full) begin
                        load_A = 1'b1; w_a_inc = 1'b1;
                    end else if (w_key == K_BKSP && !w_a_empty) begin
                        bksp_A = 1'b1; w_a_dec = 1'b1;
                        if (cnt_A == CNT_W'(1))
                            w_nxt = r_neg_a ? S_OP_A_NEG : S_START;
                    end else if (w_key == K_OP) begin
                        load_op = 1'b1; w_nxt = S_OPRND;
                    end else if (w_key == K_MS) begin
                        mem_store = 1'b1; w_mem_nxt = 1'b1;
                    end
                end
                S_OP_A_NEG: begin
                    if (w_key == K_DIG) begin
                        load_A = 1'b1; w_a_clr = 1'b1; w_a_inc = 1'b1;
                        w_neg_a_nxt = 1'b1; w_nxt = S_OP_A;
                    end else if (w_key == K_SUB || w_key == K_BKSP) begin
                        bksp_A = 1'b1; w_nxt = S_START;
                    end else if (w_key == K_MR && r_mem_valid) begin
                        mem_recall_A = 1'b1; w_a_ldmax = 1'b1;
                        w_neg_a_nxt = 1'b0; w_nxt = S_OP_A;
                    end
                end
                S_OPRND: begin
                    if (w_key == K_DIG) begin
                        load_B = 1'b1; w_b_clr = 1'b1; w_b_inc = 1'b1;
                        w_neg_b_nxt = 1'b0; w_nxt = S_OP_B;
                    end else if (w_key == K_SUB) begin
                        load_B = 1'b1; w_nxt = S_OP_B_NEG;
                    end else if (w_key == K_MR && r_mem_valid) begin
                        mem_recall_B = 1'b1; w_b_ldmax = 1'b1;
                        w_neg_b_nxt = 1'b0; w_nxt = S_OP_B;
                    end
                end
                S_OP_B: begin
                    if (w_key == K_EX) begin
                        execute = 1'b1; w_b_clr = 1'b1;
                        w_nxt = err_in ? S_ERROR : S_RESULT;
                    end else if (w_key == K_DIG && !w_b_full) begin
                        load_B = 1'b1; w_b_inc = 1'b1;
                    end else if (w_key == K_BKSP && !w_b_empty) begin
                        bksp_B = 1'b1; w_b_dec = 1'b1;
                        if (cnt_B == CNT_W'(1))
                            w_nxt = r_neg_b ? S_OP_B_NEG : S_OPRND;
                    end else if (w_key == K_OP) begin
                        load_op = 1'b1; w_nxt = S_OPRND;
                    end else if (w_key == K_MS) begin
                        mem_store = 1'b1; w_mem_nxt = 1'b1;
                    end
                end
                S_OP_B_NEG: begin
                    if (w_key == K_DIG) begin
                        load_B = 1'b1; w_b_clr = 1'b1; w_b_inc = 1'b1;
                        w_neg_b_nxt = 1'b1; w_nxt = S_OP_B;
                    end else if (w_key == K_SUB || w_key == K_BKSP) begin
                        bksp_B = 1'b1; w_nxt = S_OPRND;
                    end else if (w_key == K_MR && r_mem_valid) begin
                        mem_recall_B = 1'b1; w_b_ldmax = 1'b1;
                        w_neg_b_nxt = 1'b0; w_nxt = S_OP_B;
                    end
                end
                S_RESULT: begin
                    if (w_key == K_OP && CHAIN_EN != 0) begin
                        chain = 1'b1; load_op = 1'b1; w_a_ldmax = 1'b1;
                        w_neg_a_nxt = 1'b0; w_nxt = S_OPRND;
                    end else if (w_key == K_DIG) begin
                        reset_out = 1'b1; load_A = 1'b1; w_a_clr = 1'b1; w_a_inc = 1'b1;
                        w_neg_a_nxt = 1'b0; w_nxt = S_OP_A;
                    end else if (w_key == K_MS) begin
                        mem_store = 1'b1; w_mem_nxt = 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_key == K_MC && r_state != S_ERROR) begin
                mem_clear = 1'b1;
                w_mem_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        r_state     <= w_nxt;
        r_mem_valid <= w_mem_nxt;
        r_neg_a     <= w_neg_a_nxt;
        r_neg_b     <= w_neg_b_nxt;
    end

endmodule

// File: tb/tb_calc_control_seq.sv
// Directed and randomized key sequences against a side/phase reference model of the calculator sequencer.
module tb_calc_control_seq;
    localparam int MAXD = 4;
    localparam int CW   = 3;

    // Control word: {rst, clr, err, ex, op, sub, dig, bksp, mr, ms, mc}
    localparam logic [10:0] RST = 11'h400, CLR = 11'h200, ERR = 11'h100;
    localparam logic [10:0] EX = 11'h080, OP = 11'h040, SUB = 11'h020, DIG = 11'h010;
    localparam logic [10:0] BK = 11'h008, MR = 11'h004, MS = 11'h002, MC = 11'h001;
    localparam int KEX = 7, KOP = 6, KSUB = 5, KDIG = 4, KBK = 3, KMR = 2, KMS = 1, KMC = 0;
    // Strobe vector bit positions
    localparam int L_LA = 11, L_LB = 10, L_BA = 9, L_BB = 8, L_OP = 7, L_EX = 6;
    localparam int L_RO = 5, L_CH = 4, L_MS = 3, L_RA = 2, L_RB = 1, L_MC = 0;

    logic clock = 1'b0;
    logic reset_in = 1'b0, clr_in = 1'b0, dig_in = 1'b0, op_in = 1'b0, sub_in = 1'b0;
    logic ex_in = 1'b0, bksp_in = 1'b0, ms_in = 1'b0, mr_in = 1'b0, mc_in = 1'b0, err_in = 1'b0;
    logic load_A, load_B, bksp_A, bksp_B, load_op, execute, reset_out, chain;
    logic mem_store, mem_recall_A, mem_recall_B, mem_clear, mem_valid;
    logic [CW-1:0] cnt_A, cnt_B;
    logic [1:0] display_select;
    logic [2:0] LED;

    calc_control_seq #(.MAX_DIGITS(MAXD), .CHAIN_EN(1)) dut (
        .clock(clock), .reset_in(reset_in), .clr_in(clr_in), .dig_in(dig_in),
        .op_in(op_in), .sub_in(sub_in), .ex_in(ex_in), .bksp_in(bksp_in),
        .ms_in(ms_in), .mr_in(mr_in), .mc_in(mc_in), .err_in(err_in),
        .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
        .load_op(load_op), .execute(execute), .reset_out(reset_out), .chain(chain),
        .mem_store(mem_store), .mem_recall_A(mem_recall_A), .mem_recall_B(mem_recall_B),
        .mem_clear(mem_clear), .mem_valid(mem_valid), .cnt_A(cnt_A), .cnt_B(cnt_B),
        .display_select(display_select), .LED(LED)
    );

    always #5 clock = ~clock;

    logic [11:0] d_vec;
    assign d_vec = {load_A, load_B, bksp_A, bksp_B, load_op, execute, reset_out, chain,
                    mem_store, mem_recall_A, mem_recall_B, mem_clear};

    int n_pass = 0, n_total = 0;

    // Model: states are (side, phase) with side 0=A/1=B and phase 0=empty,1=entry,2=negative.
    int m_st = 0, n_st = 0;
    int m_cnt[2], n_cnt[2];
    bit m_neg[2], n_neg[2];
    bit m_mem = 1'b0, n_mem = 1'b0, m_known = 1'b0;
    logic [11:0] e_vec, obs_vec;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int disp_model(input int st);
        if (st < 3) return 0;
        if (st < 6) return 1;
        return (st == 6) ? 2 : 3;
    endfunction

    task automatic model_eval(input logic [10:0] c);
        int k, side, ph, ld, bk, rc;
        k = -1;
        for (int i = 7; i >= 0; i--) if (c[i] && k < 0) k = i;
        e_vec = '0;
        n_st = m_st; n_cnt = m_cnt; n_neg = m_neg; n_mem = m_mem;
        if (c[10] || c[9]) begin
            e_vec[L_RO] = 1'b1;
            n_st = 0; n_cnt[0] = 0; n_cnt[1] = 0; n_neg[0] = 0; n_neg[1] = 0;
            if (c[10]) n_mem = 1'b0;
        end else begin
            if (m_st < 6) begin
                side = m_st / 3; ph = m_st % 3;
                ld = side ? L_LB : L_LA; bk = side ? L_BB : L_BA; rc = side ? L_RB : L_RA;
                if (ph == 0) begin
                    if (k == KDIG) begin
                        e_vec[ld] = 1; n_cnt[side] = 1; n_neg[side] = 0; n_st = side * 3 + 1;
                    end else if (k == KSUB) begin
                        e_vec[ld] = 1; n_st = side * 3 + 2;
                    end else if (k == KMR && m_mem) begin
                        e_vec[rc] = 1; n_cnt[side] = MAXD; n_neg[side] = 0; n_st = side * 3 + 1;
                    end else if (side == 0) e_vec[L_RO] = 1;
                end else if (ph == 1) begin
                    if (k == KDIG) begin
                        if (m_cnt[side] < MAXD) begin e_vec[ld] = 1; n_cnt[side] = m_cnt[side] + 1; end
                    end else if (k == KBK) begin
                        e_vec[bk] = 1; n_cnt[side] = m_cnt[side] - 1;
                        if (m_cnt[side] == 1) n_st = side * 3 + (m_neg[side] ? 2 : 0);
                    end else if (k == KOP) begin
                        e_vec[L_OP] = 1; n_st = 3;
                    end else if (k == KMS) begin
                        e_vec[L_MS] = 1; n_mem = 1;
                    end else if (k == KEX && side == 1) begin
                        e_vec[L_EX] = 1; n_cnt[1] = 0; n_st = c[8] ? 7 : 6;
                    end
                end else begin
                    if (k == KDIG) begin
                        e_vec[ld] = 1; n_cnt[side] = 1; n_neg[side] = 1; n_st = side * 3 + 1;
                    end else if (k == KSUB || k == KBK) begin
                        e_vec[bk] = 1; n_st = side * 3;
                    end else if (k == KMR && m_mem) begin
                        e_vec[rc] = 1; n_cnt[side] = MAXD; n_neg[side] = 0; n_st = side * 3 + 1;
                    end
                end
            end else if (m_st == 6) begin
                if (k == KOP) begin
                    e_vec[L_CH] = 1; e_vec[L_OP] = 1; n_cnt[0] = MAXD; n_neg[0] = 0; n_st = 3;
                end else if (k == KDIG) begin
                    e_vec[L_RO] = 1; e_vec[L_LA] = 1; n_cnt[0] = 1; n_neg[0] = 0; n_st = 1;
                end else if (k == KMS) begin
                    e_vec[L_MS] = 1; n_mem = 1;
                end
            end
            if (k == KMC && m_st != 7) begin
                e_vec[L_MC] = 1; n_mem = 0;
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare Mealy outputs mid-cycle, commit model after posedge.
    task automatic step(input logic [10:0] c);
        @(negedge clock);
        {reset_in, clr_in, err_in, ex_in, op_in, sub_in, dig_in, bksp_in, mr_in, ms_in, mc_in} = c;
        #1;
        model_eval(c);
        obs_vec = d_vec;
        chk("strobes", int'(d_vec), int'(e_vec));
        if (m_known) begin
            chk("LED", int'(LED), m_st);
            chk("display_select", int'(display_select), disp_model(m_st));
            chk("cnt_A", int'(cnt_A), m_cnt[0]);
            chk("cnt_B", int'(cnt_B), m_cnt[1]);
            chk("mem_valid", int'(mem_valid), int'(m_mem));
        end
        @(posedge clock);
        #1;
        m_st = n_st; m_cnt = n_cnt; m_neg = n_neg; m_mem = n_mem;
        if (c[10]) m_known = 1'b1;
    endtask

    initial begin
        int la;
        logic [10:0] c;
        m_cnt[0] = 0; m_cnt[1] = 0; m_neg[0] = 0; m_neg[1] = 0;

        step(RST);
        chk("reset_strobes", int'(obs_vec), 32);
        chk("reset_LED", int'(LED), 0);
        chk("reset_disp", int'(display_select), 0);
        chk("reset_mem_valid", int'(mem_valid), 0);

        la = 0;
        repeat (5) begin step(DIG); la += int'(obs_vec[L_LA]); end
        chk("dig5_load_A_pulses", la, 4);
        chk("dig5_cnt_A", int'(cnt_A), 4);
        chk("dig5_LED", int'(LED), 1);

        step(CLR);
        step(SUB);  chk("neg_LED", int'(LED), 2);
        step(DIG);  chk("neg_dig_LED", int'(LED), 1);
        step(BK);   chk("neg_bksp_A", int'(obs_vec[L_BA]), 1);
        chk("neg_bksp_LED", int'(LED), 2);
        chk("neg_bksp_cnt_A", int'(cnt_A), 0);

        step(CLR); step(DIG); step(OP); step(DIG);
        step(EX);   chk("ex_execute", int'(obs_vec[L_EX]), 1);
        chk("ex_LED", int'(LED), 6);
        chk("ex_disp", int'(display_select), 2);
        step(OP);   chk("chain_strobe", int'(obs_vec[L_CH]), 1);
        chk("chain_load_op", int'(obs_vec[L_OP]), 1);
        chk("chain_LED", int'(LED), 3);

        step(CLR); step(DIG); step(OP); step(DIG);
        step(EX | ERR); chk("err_LED", int'(LED), 7);
        chk("err_disp", int'(display_select), 3);
        step(DIG);  chk("err_dig_quiet", int'(obs_vec), 0);
        step(OP);   chk("err_op_quiet", int'(obs_vec), 0);
        step(EX);   chk("err_ex_quiet", int'(obs_vec), 0);
        step(CLR);  chk("err_clr_strobes", int'(obs_vec), 32);
        chk("err_clr_LED", int'(LED), 0);

        step(DIG); step(MS); chk("ms_mem_valid", int'(mem_valid), 1);
        step(CLR);  chk("clr_keeps_mem", int'(mem_valid), 1);
        step(MR);   chk("mr_recall_A", int'(obs_vec[L_RA]), 1);
        chk("mr_LED", int'(LED), 1);
        chk("mr_cnt_A", int'(cnt_A), 4);
        step(MC);   chk("mc_mem_valid", int'(mem_valid), 0);
        step(CLR);
        step(MR);   chk("mr_empty_ignored", int'(obs_vec[L_RA]), 0);
        chk("mr_empty_LED", int'(LED), 0);

        step(DIG); step(MS);
        step(DIG | OP); chk("dig_op_priority", int'(obs_vec), 128);
        step(DIG);  chk("opb_LED", int'(LED), 4);
        step(RST);  chk("mid_rst_LED", int'(LED), 0);
        chk("mid_rst_mem_valid", int'(mem_valid), 0);

        for (int n = 0; n < 4000; n++) begin
            int r;
            c = '0;
            r = $urandom_range(0, 199);
            if (r == 0) c[10] = 1'b1;
            else if (r < 5) c[9] = 1'b1;
            if ($urandom_range(0, 9) < 3) c[8] = 1'b1;
            if ($urandom_range(0, 99) < 12) c[KEX] = 1'b1;
            if ($urandom_range(0, 99) < 10) c[KOP] = 1'b1;
            if ($urandom_range(0, 99) < 10) c[KSUB] = 1'b1;
            if ($urandom_range(0, 99) < 35) c[KDIG] = 1'b1;
            if ($urandom_range(0, 99) < 12) c[KBK] = 1'b1;
            if ($urandom_range(0, 99) < 8)  c[KMR] = 1'b1;
            if ($urandom_range(0, 99) < 8)  c[KMS] = 1'b1;
            if ($urandom_range(0, 99) < 5)  c[KMC] = 1'b1;
            step(c);
        end
        step('0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/calc_control_seq.md
Name: calc_control_seq

Overview:
- Parametrised second-generation sequencing FSM for the four-function calculator. Sits between the debounced keypad pulses and the operand/operator/result datapath.
- Adds several features to the first-generation control:
  - per-operand digit counting with a MAX_DIGITS limit;
  - memory store/recall/clear;
  - result chaining into the next operation;
  - an ERROR state driven by the datapath.
- Drives the load/backspace/execute strobes, the memory strobes and the display mux select.

Parameters:
- MAX_DIGITS, 4: maximum magnitude digits per operand; range 1..15.
- CHAIN_EN, 1: 1 = op_in in RESULT chains the result into operand A; 0 = op_in ignored in RESULT.
- CNT_W, $clog2(MAX_DIGITS+1): localparam, width of the digit counters.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_in  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- clr_in  in  1  user clear key pulse (one cycle).
- dig_in, op_in, sub_in, ex_in, bksp_in  in  1 each  keypad event pulses, one cycle.
- ms_in, mr_in, mc_in  in  1 each  memory store/recall/clear pulses.
- err_in  in  1  datapath overflow/div-by-zero flag, valid in the cycle execute=1.
- load_A, load_B, bksp_A, bksp_B, load_op, execute  out  1 each  datapath strobes.
- reset_out  out  1  clear operands/operator in the datapath.
- chain  out  1  copy result register into operand A.
- mem_store, mem_recall_A, mem_recall_B, mem_clear  out  1 each  memory strobes.
- mem_valid  out  1  memory holds a stored value.
- cnt_A, cnt_B  out  CNT_W  digits currently entered per operand.
- display_select  out  2  00 = A, 01 = B, 10 = result, 11 = error.
- LED  out  3  current state encoding.

Behaviour:
- States (3-bit encoding, LED = state): START=0, OP_A=1, OP_A_NEG=2, OPRND=3, OP_B=4, OP_B_NEG=5, RESULT=6, ERROR=7.
- Output timing:
  - All strobes are Mealy and combinational from state and inputs, asserted in the same cycle as the key pulse.
  - The state, the counters and mem_valid update on the next posedge.
  - Every strobe defaults to 0.
- reset_in (highest priority):
  - Next state START; cnt_A, cnt_B and mem_valid are cleared.
  - While reset_in is high, reset_out=1 and all other strobes are 0.
  - After reset: LED=0, display_select=00.
- clr_in (next priority): from any state, go to START and assert reset_out. Counters clear; mem_valid is kept.
- Simultaneous keys in one cycle: only the highest-priority key acts. Priority is ex > op > sub > dig > bksp > mr > ms > mc.
- START:
  - reset_out=1 while idle.
  - dig: load_A, cnt_A=1, go OP_A.
  - sub: load_A, go OP_A_NEG.
  - mr with mem_valid: mem_recall_A, cnt_A=MAX_DIGITS, go OP_A.
- OP_A:
  - dig: if cnt_A<MAX_DIGITS then load_A and cnt_A+1; at MAX_DIGITS the key is ignored.
  - bksp: bksp_A and cnt_A-1. If cnt_A was 1, go OP_A_NEG when the operand is negative, else START.
  - op: load_op, go OPRND.
  - ms: mem_store, mem_valid=1.
- OP_A_NEG:
  - dig: load_A, cnt_A=1, go OP_A.
  - sub or bksp: bksp_A, go START.
  - mr with mem_valid: as in START.
- OPRND:
  - dig: load_B, cnt_B=1, go OP_B.
  - sub: load_B, go OP_B_NEG.
  - mr with mem_valid: mem_recall_B, cnt_B=MAX_DIGITS, go OP_B.
- OP_B: same rules as OP_A, applied to load_B/bksp_B/cnt_B. Underflow of cnt_B returns to OP_B_NEG or OPRND.
- ex in OP_B: execute=1. Go ERROR if err_in=1 in the same cycle, else RESULT. cnt_B is cleared.
- OP_B_NEG: mirrors OP_A_NEG for the B strobes; sub/bksp returns to OPRND.
- RESULT:
  - ms: mem_store.
  - op with CHAIN_EN=1: chain and load_op, cnt_A=MAX_DIGITS, go OPRND.
  - dig: reset_out and load_A, cnt_A=1, go OP_A.
- ERROR: all keys except clr_in/reset_in are ignored.
- mc in any non-ERROR state: mem_clear, mem_valid=0. mr with mem_valid=0 is ignored.
- ex_in is ignored in every state except OP_B.
- display_select by state: A states (START, OP_A, OP_A_NEG) = 00; B states (OPRND, OP_B, OP_B_NEG) = 01; RESULT = 10; ERROR = 11.

Decomposition:
- Package calc_pkg holds:
  - the state localparams (shared with the display and LED logic);
  - the display_select codes;
  - the key-priority ordering.
- One sub-module, calc_digit_counter, instantiated twice (A and B):
  - saturating up/down counter with clear and load-max inputs;
  - outputs full and empty.

Test Plan:
- reset_in, then dig x5 with MAX_DIGITS=4 -> load_A pulses 4 times, 5th ignored; cnt_A=4, LED=1.
- sub, dig, bksp -> states 2,1,2; bksp_A asserted; cnt_A returns 0.
- dig, op, dig, ex with err_in=0 -> execute=1 once, LED=6, display_select=10. Then op with CHAIN_EN=1 -> chain=1, load_op=1, LED=3.
- Same sequence but err_in=1 at ex -> LED=7, display_select=11. Then dig/op/ex produce no strobes; clr_in -> LED=0, reset_out=1.
- ms in OP_A, clr_in, mr -> mem_valid stays 1, mem_recall_A=1, LED=1. Then mc -> mem_valid=0, and a later mr is ignored.
- dig and op asserted in the same cycle in OP_A -> only load_op=1. reset_in mid-entry in OP_B -> LED=0, mem_valid=0.
